// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage: IF/ID register, 32x32 write-through register file, early branch
// resolution. Define DECODE_JUMP_EN to resolve j in decode. Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrF,
  input  logic [31:0] pcPlus4F,
  input  logic        stallD,
  input  logic        forwardAD,
  input  logic        forwardBD,
  input  logic [31:0] aluOutM,
  input  logic        regWriteW,
  input  logic [4:0]  writeRegW,
  input  logic [31:0] resultW,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic [31:0] signImmD,
  output logic [31:0] pcBranchD,
  output logic        pcSrcD
);

  localparam logic [5:0] c_OP_BEQ = 6'b000100;
  localparam logic [5:0] c_OP_BNE = 6'b000101;
`ifdef DECODE_JUMP_EN
  localparam logic [5:0] c_OP_J   = 6'b000010;
`endif

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic [31:0] r_regs [32];

  logic        w_wr_en;
  logic [5:0]  w_op;
  logic [31:0] w_cmp_a;
  logic [31:0] w_cmp_b;
  logic        w_taken;
  logic [31:0] w_target;

  // IF/ID register: a taken branch squashes the slot fetched behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc4   <= '0;
    end else if (!stallD) begin
      if (pcSrcD) begin
        r_instr <= '0;
        r_pc4   <= '0;
      end else begin
        r_instr <= instrF;
        r_pc4   <= pcPlus4F;
      end
    end
  end

  assign w_wr_en = regWriteW && (writeRegW != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[writeRegW] <= resultW;
    end
  end

  assign instrD   = r_instr;
  assign pcPlus4D = r_pc4;
  assign rsD      = r_instr[25:21];
  assign rtD      = r_instr[20:16];
  assign rdD      = r_instr[15:11];
  assign signImmD = {{16{r_instr[15]}}, r_instr[15:0]};
  assign w_op     = r_instr[31:26];

  // Write-through lets a writeback in flight reach decode in the same cycle
  always_comb begin
    rd1D = r_regs[rsD];
    rd2D = r_regs[rtD];
    if (w_wr_en && (writeRegW == rsD)) rd1D = resultW;
    if (w_wr_en && (writeRegW == rtD)) rd2D = resultW;
    if (rsD == 5'd0) rd1D = '0;
    if (rtD == 5'd0) rd2D = '0;
  end

  assign w_cmp_a = forwardAD ? aluOutM : rd1D;
  assign w_cmp_b = forwardBD ? aluOutM : rd2D;

  always_comb begin
    w_taken  = 1'b0;
    w_target = r_pc4 + {signImmD[29:0], 2'b00};
    case (w_op)
      c_OP_BEQ: w_taken = (w_cmp_a == w_cmp_b);
      c_OP_BNE: w_taken = (w_cmp_a != w_cmp_b);
`ifdef DECODE_JUMP_EN
      c_OP_J: begin
        w_taken  = 1'b1;
        w_target = {r_pc4[31:28], r_instr[25:0], 2'b00};
      end
`endif
      default: w_taken = 1'b0;
    endcase
  end

  // A stalled branch may still be waiting on operands, so it never redirects
  assign pcSrcD    = w_taken & ~stallD;
  assign pcBranchD = w_target;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic
// checked against a behavioural pipeline model.
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrF, pcPlus4F, aluOutM, resultW;
  logic        stallD, forwardAD, forwardBD, regWriteW;
  logic [4:0]  writeRegW;
  logic [31:0] instrD, pcPlus4D, rd1D, rd2D, signImmD, pcBranchD;
  logic [4:0]  rsD, rtD, rdD;
  logic        pcSrcD;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instrF(instrF), .pcPlus4F(pcPlus4F),
    .stallD(stallD), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .aluOutM(aluOutM), .regWriteW(regWriteW), .writeRegW(writeRegW),
    .resultW(resultW), .instrD(instrD), .pcPlus4D(pcPlus4D),
    .rd1D(rd1D), .rd2D(rd2D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .signImmD(signImmD), .pcBranchD(pcBranchD), .pcSrcD(pcSrcD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (regWriteW && writeRegW == a) return resultW;
    return m_regs[a];
  endfunction

  function automatic logic m_taken();
    logic [31:0] a, b;
    a = forwardAD ? aluOutM : m_read(m_instr[25:21]);
    b = forwardBD ? aluOutM : m_read(m_instr[20:16]);
`ifdef DECODE_JUMP_EN
    if (m_instr[31:26] == 6'd2) return 1'b1;
`endif
    if (m_instr[31:26] == 6'd4) return a == b;
    if (m_instr[31:26] == 6'd5) return a != b;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_target();
    int signed imm;
`ifdef DECODE_JUMP_EN
    if (m_instr[31:26] == 6'd2) return {m_pc4[31:28], m_instr[25:0], 2'b00};
`endif
    imm = $signed(m_instr[15:0]);
    return m_pc4 + 32'(imm * 4);
  endfunction

  task automatic tick();
    logic src;
    src = m_taken() && !stallD;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instr = 32'd0;
      m_pc4   = 32'd0;
    end else begin
      if (regWriteW && writeRegW != 5'd0) m_regs[writeRegW] = resultW;
      if (!stallD) begin
        m_instr = src ? 32'd0 : instrF;
        m_pc4   = src ? 32'd0 : pcPlus4F;
      end
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    instrF = 0; pcPlus4F = 0; stallD = 0;
    regWriteW = 1; writeRegW = a; resultW = d;
    tick();
    regWriteW = 0;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
    instrF = ins; pcPlus4F = pc4; stallD = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0; instrF = 32'h8C080004; pcPlus4F = 32'h4;
    tick(); tick();
    if (instrD !== 32'd0) begin errors++; $display("FAIL reset_instrD got %h exp 0", instrD); end
    checks++;
    if (pcSrcD !== 1'b0) begin errors++; $display("FAIL reset_pcSrcD got %b exp 0", pcSrcD); end
    checks++;
    if (pcPlus4D !== 32'd0 || pcBranchD !== 32'd0 || signImmD !== 32'd0) begin
      errors++; $display("FAIL reset_fields pc4 %h br %h imm %h exp 0", pcPlus4D, pcBranchD, signImmD);
    end
    checks++;
    rst_n = 1;
    load(32'h01000020, 32'h4);
    if (rd1D !== 32'd0) begin errors++; $display("FAIL reset_reg8 got %h exp 0", rd1D); end
    checks++;
  endtask

  task automatic test_writethrough();
    load(32'h01000020, 32'h8);
    regWriteW = 1; writeRegW = 8; resultW = 32'h1234;
    #1;
    if (rd1D !== 32'h1234) begin errors++; $display("FAIL wt_same_cycle got %h exp 1234", rd1D); end
    checks++;
    tick();
    regWriteW = 0; #1;
    if (rd1D !== 32'h1234) begin errors++; $display("FAIL wt_stored got %h exp 1234", rd1D); end
    checks++;
    load(32'h00000020, 32'hC);
    regWriteW = 1; writeRegW = 0; resultW = 32'hFFFF; #1;
    if (rd1D !== 32'd0) begin errors++; $display("FAIL wt_r0_same got %h exp 0", rd1D); end
    checks++;
    tick();
    regWriteW = 0; #1;
    if (rd1D !== 32'd0 || rd2D !== 32'd0) begin errors++; $display("FAIL wt_r0_after got %h/%h exp 0", rd1D, rd2D); end
    checks++;
  endtask

  task automatic test_beq();
    wr(8, 5); wr(9, 5); load(0, 0);
    load(32'h11090003, 32'h104);
    if (pcSrcD !== 1'b1 || pcBranchD !== 32'h110) begin
      errors++; $display("FAIL beq_taken src %b br %h exp 1/110", pcSrcD, pcBranchD);
    end
    checks++;
    load(32'h2008FFFF, 32'h108);
    if (instrD !== 32'd0 || pcPlus4D !== 32'd0) begin
      errors++; $display("FAIL beq_squash instr %h pc4 %h exp 0", instrD, pcPlus4D);
    end
    checks++;
  endtask

  task automatic test_bne_fwd();
    wr(8, 5); wr(9, 7); load(0, 0);
    load(32'h15090010, 32'h200);
    aluOutM = 5; forwardBD = 1; #1;
    if (pcSrcD !== 1'b0) begin errors++; $display("FAIL bne_fwd got %b exp 0", pcSrcD); end
    checks++;
    forwardBD = 0; #1;
    if (pcSrcD !== 1'b1 || pcBranchD !== 32'h240) begin
      errors++; $display("FAIL bne_nofwd src %b br %h exp 1/240", pcSrcD, pcBranchD);
    end
    checks++;
    load(0, 0); load(0, 0);
  endtask

  task automatic test_stall();
    wr(9, 5); load(0, 0);
    load(32'h11090003, 32'h104);
    instrF = 32'hDEADBEEF; pcPlus4F = 32'h500; stallD = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (pcSrcD !== 1'b0 || instrD !== 32'h11090003) begin
        errors++; $display("FAIL stall_hold cyc %0d src %b instr %h exp 0/11090003", i, pcSrcD, instrD);
      end
      checks++;
      tick();
    end
    stallD = 0; #1;
    if (pcSrcD !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", pcSrcD); end
    checks++;
    tick();
    if (instrD !== 32'd0) begin errors++; $display("FAIL stall_squash got %h exp 0", instrD); end
    checks++;
  endtask

  task automatic test_jump();
    load(0, 0);
    load(32'h08000040, 32'h40000008);
`ifdef DECODE_JUMP_EN
    if (pcSrcD !== 1'b1 || pcBranchD !== 32'h40000100) begin
      errors++; $display("FAIL jump src %b br %h exp 1/40000100", pcSrcD, pcBranchD);
    end
`else
    if (pcSrcD !== 1'b0 || pcBranchD !== 32'h40000108) begin
      errors++; $display("FAIL jump_off src %b br %h exp 0/40000108", pcSrcD, pcBranchD);
    end
`endif
    checks++;
    load(0, 0); load(0, 0);
  endtask

  task automatic test_mid_reset();
    wr(8, 32'hABCD);
    rst_n = 0; stallD = 1; regWriteW = 1; writeRegW = 9; resultW = 32'h77;
    tick();
    rst_n = 1; regWriteW = 0;
    if (instrD !== 32'd0) begin errors++; $display("FAIL midrst_instr got %h exp 0", instrD); end
    checks++;
    load(32'h01090000, 32'h4);
    if (rd1D !== 32'd0 || rd2D !== 32'd0) begin
      errors++; $display("FAIL midrst_regs got %h/%h exp 0", rd1D, rd2D);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic       exp_src;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'd0;
        1: op = 6'd4;
        2: op = 6'd5;
        3: op = 6'd2;
        default: op = 6'($urandom);
      endcase
      instrF    = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      pcPlus4F  = $urandom;
      stallD    = ($urandom_range(0, 4) == 0);
      forwardAD = $urandom_range(0, 1) == 1;
      forwardBD = $urandom_range(0, 1) == 1;
      aluOutM   = $urandom_range(0, 3);
      regWriteW = $urandom_range(0, 1) == 1;
      writeRegW = 5'($urandom_range(0, 3));
      resultW   = $urandom_range(0, 3);
      rst_n     = ($urandom_range(0, 60) != 0);
      #1;
      exp_src = m_taken() && !stallD;
      if (instrD !== m_instr || pcPlus4D !== m_pc4) begin
        errors++; $display("FAIL rand_ifid it %0d got %h/%h exp %h/%h", n, instrD, pcPlus4D, m_instr, m_pc4);
      end
      checks++;
      if (rd1D !== m_read(m_instr[25:21]) || rd2D !== m_read(m_instr[20:16])) begin
        errors++; $display("FAIL rand_rd it %0d got %h/%h exp %h/%h", n, rd1D, rd2D,
                           m_read(m_instr[25:21]), m_read(m_instr[20:16]));
      end
      checks++;
      if (rsD !== m_instr[25:21] || rtD !== m_instr[20:16] || rdD !== m_instr[15:11] ||
          signImmD !== 32'($signed(m_instr[15:0]))) begin
        errors++; $display("FAIL rand_fields it %0d rs %h rt %h rd %h imm %h instr %h", n, rsD, rtD, rdD, signImmD, m_instr);
      end
      checks++;
      if (pcSrcD !== exp_src || pcBranchD !== m_target()) begin
        errors++; $display("FAIL rand_branch it %0d got %b/%h exp %b/%h", n, pcSrcD, pcBranchD, exp_src, m_target());
      end
      checks++;
      tick();
    end
    rst_n = 1; regWriteW = 0; stallD = 0; forwardAD = 0; forwardBD = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instr = 0; m_pc4 = 0;
    rst_n = 0; instrF = 0; pcPlus4F = 0; stallD = 0; forwardAD = 0; forwardBD = 0;
    aluOutM = 0; regWriteW = 0; writeRegW = 0; resultW = 0;
    @(negedge clk);
    test_reset();
    test_writethrough();
    test_beq();
    test_bne_fwd();
    test_stall();
    test_jump();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage MIPS pipeline, directly downstream of instruction fetch. Holds the IF/ID pipeline register, the 32×32 register file, and the early branch-resolution logic. Consumes the fetched instruction and PC+4. Returns the branch target and PC-select to fetch, and presents register operands and immediate fields to execute.

## Interface
Parameters: none.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instrF  in  32  instruction from fetch
- pcPlus4F  in  32  PC+4 from fetch
- stallD  in  1  hazard unit: hold IF/ID contents
- forwardAD  in  1  comparator operand A takes aluOutM instead of register file
- forwardBD  in  1  comparator operand B takes aluOutM instead of register file
- aluOutM  in  32  memory-stage ALU result, used for forwarding
- regWriteW  in  1  writeback enable
- writeRegW  in  5  writeback destination register
- resultW  in  32  writeback data
- instrD  out  32  registered instruction
- pcPlus4D  out  32  registered PC+4
- rd1D, rd2D  out  32 each  register-file read data for rs and rt (unforwarded)
- rsD, rtD, rdD  out  5 each  instrD[25:21], [20:16], [15:11]
- signImmD  out  32  sign-extended instrD[15:0]
- pcBranchD  out  32  redirect target to fetch
- pcSrcD  out  1  redirect fetch to pcBranchD

## Operation
IF/ID register update priority at each edge:
1. rst_n=0 → load 0 (instrD=0 is sll $0,$0,0, a nop).
2. Else stallD=1 → hold.
3. Else pcSrcD=1 → load 0. This squashes the instruction fetched behind a taken branch.
4. Else → load instrF and pcPlus4F.

Register file:
- 32 entries of 32 bits. Reset clears all entries to 0.
- Write at the edge when regWriteW=1 and writeRegW≠0. Writes to $0 are ignored.
- Reads are combinational with write-through. If regWriteW=1, writeRegW≠0 and writeRegW equals the read address, the read returns resultW in the same cycle.
- Address 0 always reads 0.

Branch resolution (combinational from IF/ID state):
- cmpA = forwardAD ? aluOutM : rd1D
- cmpB = forwardBD ? aluOutM : rd2D
- beq is opcode 6'b000100: taken when cmpA==cmpB.
- bne is opcode 6'b000101: taken when cmpA≠cmpB.
- pcBranchD = pcPlus4D + (signImmD<<2), 32-bit arithmetic with silent wrap.
- pcSrcD = taken & ~stallD. A stalled branch has unresolved operands and must never redirect.

Reset output values: instrD, pcPlus4D, rd1D, rd2D, rsD, rtD, rdD, signImmD = 0; pcBranchD = 0; pcSrcD = 0.

## Timing
- instrF/pcPlus4F to instrD/pcPlus4D: 1 cycle.
- All other outputs are combinational from IF/ID state, the register file and the forwarding inputs. They are valid in the same cycle.
- Writeback write becomes visible in the same cycle via write-through. It is stored at the following edge.
- Taken branch: pcSrcD is high for one cycle, fetch redirects at the next edge, and IF/ID loads a nop at that same edge. Exactly one squashed slot.
- Simultaneous stallD and taken condition: pcSrcD=0 and IF/ID holds. Branch re-evaluates next cycle.
- Reset mid-operation clears IF/ID and the register file at that edge, regardless of stallD or regWriteW.

## Configuration
- DECODE_JUMP_EN defined: opcode 6'b000010 (j) sets taken=1 unconditionally. pcBranchD = {pcPlus4D[31:28], instrD[25:0], 2'b00}. pcSrcD is still gated by ~stallD.
- Undefined: j is not recognised. pcSrcD=0 and pcBranchD follows the branch formula.

## Test plan
- Reset: rst_n=0 for 2 cycles with instrF=0x8C080004 → instrD=0, pcSrcD=0; $8 reads 0 after release.
- Write-through: regWriteW=1, writeRegW=8, resultW=0x1234 while instrD reads $8 → rd1D=0x1234 the same cycle; next cycle still 0x1234. A write to $0 with 0xFFFF leaves $0 reading 0.
- beq taken: $8=$9=5, instr beq $8,$9,+3 at pcPlus4D=0x104 → pcSrcD=1, pcBranchD=0x110; next instrD=0.
- bne with forwarding: $8=5, $9=7, aluOutM=5, forwardBD=1, bne $8,$9 → not taken, pcSrcD=0. Repeat with forwardBD=0 → taken.
- Stall: stallD=1 for 3 cycles holding a taken beq → pcSrcD=0 and instrD unchanged throughout; stallD=0 → pcSrcD=1.
- Jump (DECODE_JUMP_EN): j 0x0000040 at pcPlus4D=0x40000008 → pcSrcD=1, pcBranchD=0x40000100. Without the macro → pcSrcD=0.
